stream_arbiter: RTL and testbench
=================================

STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 Parameter T_DATA_WIDTH, default 32, sets the beat data width in bits.
REQ-002 Parameter N_SRC, default 3, sets the number of requesting streams; legal range 2..8.
REQ-003 Parameter ID_WIDTH, default $clog2(N_SRC), sets the source-id width.
REQ-004 clk  input  1  Single clock; all state updates on the rising edge.
REQ-005 rst  input  1  Asynchronous, active-high reset.
REQ-006 s_data  input  [N_SRC][T_DATA_WIDTH]  Per-source beat data.
REQ-007 s_last  input  [N_SRC]  Per-source end-of-packet flag.
REQ-008 s_valid  input  [N_SRC]  Per-source beat valid.
REQ-009 s_ready  output  [N_SRC]  Per-source beat accept.
REQ-010 m_data  output  T_DATA_WIDTH  Registered output beat, feeding the shared downsizer.
REQ-011 m_last  output  1  Registered end-of-packet flag.
REQ-012 m_id  output  ID_WIDTH  Index of the source that produced the beat in the output register.
REQ-013 m_valid  output  1  Output register holds a beat.
REQ-014 m_ready  input  1  Downstream accepts the beat.

Function
REQ-015 The arbiter SHALL be a two-state FSM (IDLE, GRANT) with a grant index g and a round-robin pointer p.
REQ-016 In IDLE with any s_valid high, the arbiter SHALL select the first requester at or after (p+1) mod N_SRC, load g, and enter GRANT on the next edge.
REQ-017 In IDLE with no s_valid high, the arbiter SHALL remain in IDLE.
REQ-018 In IDLE, every s_ready bit SHALL be 0.
REQ-019 In GRANT, s_ready[g] SHALL equal (!m_valid || m_ready), and all other s_ready bits SHALL be 0; this path is combinational.
REQ-020 A source beat SHALL transfer when s_valid[g] && s_ready[g] in GRANT.
REQ-021 On a transfer, the output register SHALL load m_data=s_data[g], m_last=s_last[g], m_id=g, and m_valid=1 on the same edge.
REQ-022 When m_valid && m_ready and no transfer occurs, m_valid SHALL clear; the other output fields hold their values.
REQ-023 While m_valid=1 and m_ready=0, m_data, m_last and m_id SHALL remain stable.
REQ-024 When a transfer has s_last[g]=1, the arbiter SHALL set p<=g and return to IDLE on that edge.
REQ-025 The grant SHALL be held until the last beat transfers, regardless of s_valid[g] dropping mid-packet or other sources requesting.
REQ-026 Latency from the first s_valid in IDLE to m_valid SHALL be 2 cycles: grant on cycle 1, m_valid on cycle 2.
REQ-027 Steady-state throughput within a packet SHALL be 1 beat per cycle when m_ready=1.
REQ-028 Exactly one IDLE cycle SHALL separate consecutive packets.
REQ-029 A single-beat packet (s_last=1 on the first beat) SHALL occupy GRANT for one cycle.
REQ-030 A simultaneous output drain and new transfer SHALL keep m_valid=1 and load the new beat.
REQ-031 With all sources continuously requesting, the grant order SHALL be 0,1,…,N_SRC-1,0,…

Reset
REQ-032 While rst=1, the block SHALL force: state=IDLE, p=N_SRC-1 (source 0 wins first), g=0, m_valid=0, m_last=0, m_data=0, m_id=0, s_ready=0.
REQ-033 Assertion of rst mid-packet SHALL discard the partial packet and the output-register contents immediately.
REQ-034 After rst deasserts, arbitration SHALL restart from IDLE with no stale grant.

Verification
REQ-035 Single source: src0 sends 1,2,3 with last on 3, m_ready=1 -> m_data 1,2,3 on consecutive cycles starting 2 cycles after s_valid; m_last only on 3; m_id=0.
REQ-036 Contention: src0 (a,b,last) and src2 (c,last) valid together after reset -> src0 packet first, one idle cycle, then c with m_id=2; src2's s_ready stays 0 during src0's packet.
REQ-037 Fairness: all three sources stream single-beat packets continuously -> m_id sequence 0,1,2,0,1,2.
REQ-038 Backpressure: hold m_ready=0 for 3 cycles mid-packet -> m_data/m_last stable, s_ready[g]=0, no beat lost or duplicated after release.
REQ-039 Gap: src1 drops s_valid for 2 cycles mid-packet while src0 requests -> grant stays on 1 until src1's last beat, then src0 is granted.
REQ-040 Reset mid-packet: assert rst after beat 2 of a 4-beat packet -> m_valid=0 and s_ready=0 immediately; after release, src0 wins the first arbitration.

Source files
------------

// File: rtl/stream_arbiter_if.sv
// Handshake bundle between N_SRC input streams, the arbiter and the shared downstream port.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface stream_arbiter_if #(
  parameter int T_DATA_WIDTH = 32,
  parameter int N_SRC        = 3,
  parameter int ID_WIDTH     = $clog2(N_SRC)
);
  logic [N_SRC-1:0][T_DATA_WIDTH-1:0] s_data;
  logic [N_SRC-1:0]                   s_last;
  logic [N_SRC-1:0]                   s_valid;
  logic [N_SRC-1:0]                   s_ready;
  logic [T_DATA_WIDTH-1:0]            m_data;
  logic                               m_last;
  logic [ID_WIDTH-1:0]                m_id;
  logic                               m_valid;
  logic                               m_ready;

  modport master (
    input  s_data, s_last, s_valid, m_ready,
    output s_ready, m_data, m_last, m_id, m_valid
  );

  modport slave (
    output s_data, s_last, s_valid, m_ready,
    input  s_ready, m_data, m_last, m_id, m_valid
  );
endinterface

// File: rtl/stream_arbiter.sv
// Packet-granular round-robin arbiter: merges N_SRC streams into one registered
// output beat stage, holding each grant until the packet's last beat transfers.
module stream_arbiter #(
  parameter int T_DATA_WIDTH = 32,
  parameter int N_SRC        = 3,
  parameter int ID_WIDTH     = $clog2(N_SRC)
) (
  input logic              clk,
  input logic              rst,
  stream_arbiter_if.master bus
);
  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     g_q, g_d;
  logic [ID_WIDTH-1:0]     p_q, p_d;
  logic [ID_WIDTH-1:0]     m_id_q, m_id_d;
  logic [T_DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                    m_last_q, m_last_d;
  logic                    m_valid_q, m_valid_d;
  logic [ID_WIDTH-1:0]     sel_s;
  logic                    found_s;
  logic                    room_s;
  logic                    xfer_s;
  logic [N_SRC-1:0]        s_ready_s;

  // Round-robin pick: first requester at or after p+1, wrapping modulo N_SRC.
  always_comb begin
    sel_s   = '0;
    found_s = 1'b0;
    for (int i = 1; i <= N_SRC; i++) begin
      if (!found_s && bus.s_valid[(int'(p_q) + i) % N_SRC]) begin
        found_s = 1'b1;
        sel_s   = ID_WIDTH'((int'(p_q) + i) % N_SRC);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state, grant-side ready and output-register load logic.
  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    p_d       = p_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_id_d    = m_id_q;
    s_ready_s = '0;
    room_s    = !m_valid_q || bus.m_ready;
    xfer_s    = 1'b0;
    // A drain empties the output stage unless a transfer below refills it.
    if (m_valid_q && bus.m_ready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d = GRANT;
          g_d     = sel_s;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        s_ready_s[g_q] = room_s;
        xfer_s         = bus.s_valid[g_q] && room_s;
        if (xfer_s) begin
          m_data_d  = bus.s_data[g_q];
          m_last_d  = bus.s_last[g_q];
          m_id_d    = g_q;
          m_valid_d = 1'b1;
          if (bus.s_last[g_q]) begin
            p_d     = g_q;
            state_d = IDLE;
          end else begin
            state_d = GRANT;
          end
        end else begin
          state_d = GRANT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset makes source 0 the first winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      g_q       <= '0;
      p_q       <= ID_WIDTH'(N_SRC - 1);
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_id_q    <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      p_q       <= p_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      m_id_q    <= m_id_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign bus.s_ready = s_ready_s;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;
  assign bus.m_id    = m_id_q;
  assign bus.m_valid = m_valid_q;
endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter: per-cycle tables of expected s_ready and output beat.
// Table entry: [15]=hold m_ready low, [14:12]=s_ready, [11]=m_valid, [10]=m_last, [9:8]=m_id, [7:0]=m_data.
module tb_stream_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] q2[$];
  logic [2:0] gate = 3'b111;
  logic [2:0] rdy_seen;
  logic [2:0] xfer;

  stream_arbiter_if #(.T_DATA_WIDTH(32), .N_SRC(3)) bus ();

  stream_arbiter #(.T_DATA_WIDTH(32), .N_SRC(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Present queue heads, note the handshake before the edge, pop accepted beats after it.
  task automatic run_cycle(input logic hold);
    bus.m_ready    = ~hold;
    bus.s_valid    = gate & {q2.size() > 0, q1.size() > 0, q0.size() > 0};
    bus.s_data[0]  = (q0.size() > 0) ? {24'h0, q0[0][7:0]} : 32'h0;
    bus.s_last[0]  = (q0.size() > 0) ? q0[0][8] : 1'b0;
    bus.s_data[1]  = (q1.size() > 0) ? {24'h0, q1[0][7:0]} : 32'h0;
    bus.s_last[1]  = (q1.size() > 0) ? q1[0][8] : 1'b0;
    bus.s_data[2]  = (q2.size() > 0) ? {24'h0, q2[0][7:0]} : 32'h0;
    bus.s_last[2]  = (q2.size() > 0) ? q2[0][8] : 1'b0;
    #1;
    rdy_seen = bus.s_ready;
    xfer     = bus.s_valid & bus.s_ready;
    @(posedge clk);
    #1;
    if (xfer[0]) void'(q0.pop_front());
    if (xfer[1]) void'(q1.pop_front());
    if (xfer[2]) void'(q2.pop_front());
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    q0.delete();
    q1.delete();
    q2.delete();
    gate        = 3'b111;
    bus.s_valid = 3'b000;
    bus.s_last  = 3'b000;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.s_valid = 3'b111;
    bus.s_last  = 3'b000;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset m_valid got %b want 0", bus.m_valid); end
    vectors++;
    if (bus.s_ready !== 3'b000) begin errors++; $display("FAIL reset s_ready got %b want 000", bus.s_ready); end
    vectors++;
    if ({bus.m_last, bus.m_id, bus.m_data} !== 35'h0) begin
      errors++; $display("FAIL reset fields got last=%b id=%0d data=%h want 0", bus.m_last, bus.m_id, bus.m_data);
    end
  endtask

  task automatic test_single();
    logic [15:0] t [5];
    t = '{16'h0000, 16'h1801, 16'h1802, 16'h1C03, 16'h0000};
    do_reset();
    q0 = '{9'h001, 9'h002, 9'h103};
    for (int c = 0; c < 5; c++) begin
      run_cycle(t[c][15]);
      vectors++;
      if (rdy_seen !== t[c][14:12]) begin errors++; $display("FAIL single c%0d s_ready got %b want %b", c, rdy_seen, t[c][14:12]); end
      vectors++;
      if (bus.m_valid !== t[c][11]) begin errors++; $display("FAIL single c%0d m_valid got %b want %b", c, bus.m_valid, t[c][11]); end
      if (t[c][11]) begin
        vectors++;
        if ({bus.m_last, bus.m_id, bus.m_data} !== {t[c][10], t[c][9:8], 24'h0, t[c][7:0]}) begin
          errors++; $display("FAIL single c%0d beat got last=%b id=%0d data=%h want last=%b id=%0d data=%h",
                             c, bus.m_last, bus.m_id, bus.m_data, t[c][10], t[c][9:8], t[c][7:0]);
        end
      end
    end
  endtask

  task automatic test_contention();
    logic [15:0] t [6];
    t = '{16'h0000, 16'h180A, 16'h1C0B, 16'h0000, 16'h4E0C, 16'h0000};
    do_reset();
    q0 = '{9'h00A, 9'h10B};
    q2 = '{9'h10C};
    for (int c = 0; c < 6; c++) begin
      run_cycle(t[c][15]);
      vectors++;
      if (rdy_seen !== t[c][14:12]) begin errors++; $display("FAIL contention c%0d s_ready got %b want %b", c, rdy_seen, t[c][14:12]); end
      vectors++;
      if (bus.m_valid !== t[c][11]) begin errors++; $display("FAIL contention c%0d m_valid got %b want %b", c, bus.m_valid, t[c][11]); end
      if (t[c][11]) begin
        vectors++;
        if ({bus.m_last, bus.m_id, bus.m_data} !== {t[c][10], t[c][9:8], 24'h0, t[c][7:0]}) begin
          errors++; $display("FAIL contention c%0d beat got last=%b id=%0d data=%h want last=%b id=%0d data=%h",
                             c, bus.m_last, bus.m_id, bus.m_data, t[c][10], t[c][9:8], t[c][7:0]);
        end
      end
    end
  endtask

  task automatic test_fairness();
    logic [15:0] t [13];
    t = '{16'h0000, 16'h1C01, 16'h0000, 16'h2D02, 16'h0000, 16'h4E03, 16'h0000,
          16'h1C04, 16'h0000, 16'h2D05, 16'h0000, 16'h4E06, 16'h0000};
    do_reset();
    q0 = '{9'h101, 9'h104};
    q1 = '{9'h102, 9'h105};
    q2 = '{9'h103, 9'h106};
    for (int c = 0; c < 13; c++) begin
      run_cycle(t[c][15]);
      vectors++;
      if (rdy_seen !== t[c][14:12]) begin errors++; $display("FAIL fairness c%0d s_ready got %b want %b", c, rdy_seen, t[c][14:12]); end
      vectors++;
      if (bus.m_valid !== t[c][11]) begin errors++; $display("FAIL fairness c%0d m_valid got %b want %b", c, bus.m_valid, t[c][11]); end
      if (t[c][11]) begin
        vectors++;
        if ({bus.m_last, bus.m_id, bus.m_data} !== {t[c][10], t[c][9:8], 24'h0, t[c][7:0]}) begin
          errors++; $display("FAIL fairness c%0d beat got last=%b id=%0d data=%h want last=%b id=%0d data=%h",
                             c, bus.m_last, bus.m_id, bus.m_data, t[c][10], t[c][9:8], t[c][7:0]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] t [9];
    t = '{16'h0000, 16'h1811, 16'h1812, 16'h8812, 16'h8812, 16'h8812, 16'h1813, 16'h1C14, 16'h0000};
    do_reset();
    q0 = '{9'h011, 9'h012, 9'h013, 9'h114};
    for (int c = 0; c < 9; c++) begin
      run_cycle(t[c][15]);
      vectors++;
      if (rdy_seen !== t[c][14:12]) begin errors++; $display("FAIL backpressure c%0d s_ready got %b want %b", c, rdy_seen, t[c][14:12]); end
      vectors++;
      if (bus.m_valid !== t[c][11]) begin errors++; $display("FAIL backpressure c%0d m_valid got %b want %b", c, bus.m_valid, t[c][11]); end
      if (t[c][11]) begin
        vectors++;
        if ({bus.m_last, bus.m_id, bus.m_data} !== {t[c][10], t[c][9:8], 24'h0, t[c][7:0]}) begin
          errors++; $display("FAIL backpressure c%0d beat got last=%b id=%0d data=%h want last=%b id=%0d data=%h",
                             c, bus.m_last, bus.m_id, bus.m_data, t[c][10], t[c][9:8], t[c][7:0]);
        end
      end
    end
  endtask

  task automatic test_gap();
    logic [15:0] t [9];
    logic [2:0]  gm [9];
    t  = '{16'h0000, 16'h2921, 16'h2000, 16'h2000, 16'h2922, 16'h2D23, 16'h0000, 16'h1C31, 16'h0000};
    gm = '{3'b010, 3'b011, 3'b001, 3'b001, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011};
    do_reset();
    q1 = '{9'h021, 9'h022, 9'h123};
    q0 = '{9'h131};
    for (int c = 0; c < 9; c++) begin
      gate = gm[c];
      run_cycle(t[c][15]);
      vectors++;
      if (rdy_seen !== t[c][14:12]) begin errors++; $display("FAIL gap c%0d s_ready got %b want %b", c, rdy_seen, t[c][14:12]); end
      vectors++;
      if (bus.m_valid !== t[c][11]) begin errors++; $display("FAIL gap c%0d m_valid got %b want %b", c, bus.m_valid, t[c][11]); end
      if (t[c][11]) begin
        vectors++;
        if ({bus.m_last, bus.m_id, bus.m_data} !== {t[c][10], t[c][9:8], 24'h0, t[c][7:0]}) begin
          errors++; $display("FAIL gap c%0d beat got last=%b id=%0d data=%h want last=%b id=%0d data=%h",
                             c, bus.m_last, bus.m_id, bus.m_data, t[c][10], t[c][9:8], t[c][7:0]);
        end
      end
    end
    gate = 3'b111;
  endtask

  task automatic test_reset_mid_packet();
    logic [15:0] t [8];
    t = '{16'h0000, 16'h2941, 16'h2942, 16'h0000, 16'h1C51, 16'h0000, 16'h2D61, 16'h0000};
    do_reset();
    q1 = '{9'h041, 9'h042, 9'h043, 9'h144};
    for (int c = 0; c < 8; c++) begin
      if (c == 3) begin
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid m_valid got %b want 0", bus.m_valid); end
        vectors++;
        if (bus.s_ready !== 3'b000) begin errors++; $display("FAIL rst_mid s_ready got %b want 000", bus.s_ready); end
        vectors++;
        if (bus.m_data !== 32'h0) begin errors++; $display("FAIL rst_mid m_data got %h want 0", bus.m_data); end
        q1.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        q0 = '{9'h151};
        q1 = '{9'h161};
      end
      run_cycle(t[c][15]);
      vectors++;
      if (rdy_seen !== t[c][14:12]) begin errors++; $display("FAIL rst_mid c%0d s_ready got %b want %b", c, rdy_seen, t[c][14:12]); end
      vectors++;
      if (bus.m_valid !== t[c][11]) begin errors++; $display("FAIL rst_mid c%0d m_valid got %b want %b", c, bus.m_valid, t[c][11]); end
      if (t[c][11]) begin
        vectors++;
        if ({bus.m_last, bus.m_id, bus.m_data} !== {t[c][10], t[c][9:8], 24'h0, t[c][7:0]}) begin
          errors++; $display("FAIL rst_mid c%0d beat got last=%b id=%0d data=%h want last=%b id=%0d data=%h",
                             c, bus.m_last, bus.m_id, bus.m_data, t[c][10], t[c][9:8], t[c][7:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_backpressure();
    test_gap();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
